// File: rtl/usb_host_port_controller.sv
// -----------------------------------------------------------------------------
// usb_host_port_controller
//
// Per-port host-side sequencer for one downstream USB port. It watches the
// sampled D+/D- line, debounces device attach, latches full/low speed from the
// J-state polarity, drives bus reset (SE0), runs reset recovery, enables the
// port and detects disconnect. It owns the transceiver SE0/K drive enables.
//
// Optional feature: define USB_PORT_SUSPEND_EN to add the SUSPENDED and
// RESUMING states (host resume and remote wakeup). Without it, suspend_req and
// resume_req are ignored, drive_k is constant 0, and states 6/7 are illegal.
//
// Ports:
//   clock            in   system clock
//   reset            in   asynchronous, active-high reset
//   usb_line[1:0]    in   sampled line, [1]=D+, [0]=D- (10 FS J, 01 LS J,
//                         00 SE0, 11 SE1)
//   port_reset_req   in   level: request bus reset
//   port_disable_req in   level: request port disable
//   suspend_req      in   level: request suspend (feature only)
//   resume_req       in   level: request host resume (feature only)
//   drive_en         out  transceiver output enable
//   drive_se0        out  drive SE0 (valid with drive_en)
//   drive_k          out  drive K (valid with drive_en)
//   port_state[2:0]  out  current state encoding
//   connected        out  device present (ATTACHED or later)
//   port_enabled     out  state is ENABLED
//   low_speed        out  latched speed, 1 = low speed
//   connect_pulse    out  one cycle: attach accepted
//   disconnect_pulse out  one cycle: disconnect
//   reset_done_pulse out  one cycle: RECOVERY -> ENABLED
//   port_error_pulse out  one cycle: SE1 seen at recovery end
// -----------------------------------------------------------------------------
module usb_host_port_controller #(
    parameter int unsigned DEBOUNCE_CYCLES   = 100,
    parameter int unsigned BUS_RESET_CYCLES  = 1000,
    parameter int unsigned RECOVERY_CYCLES   = 10,
    parameter int unsigned DISCONNECT_CYCLES = 20,
    parameter int unsigned RESUME_CYCLES     = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] usb_line,
    input  logic       port_reset_req,
    input  logic       port_disable_req,
    input  logic       suspend_req,
    input  logic       resume_req,
    output logic       drive_en,
    output logic       drive_se0,
    output logic       drive_k,
    output logic [2:0] port_state,
    output logic       connected,
    output logic       port_enabled,
    output logic       low_speed,
    output logic       connect_pulse,
    output logic       disconnect_pulse,
    output logic       reset_done_pulse,
    output logic       port_error_pulse
);

    localparam logic [2:0] ST_DISCONNECTED = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE     = 3'd1;
    localparam logic [2:0] ST_ATTACHED     = 3'd2;
    localparam logic [2:0] ST_BUS_RESET    = 3'd3;
    localparam logic [2:0] ST_RECOVERY     = 3'd4;
    localparam logic [2:0] ST_ENABLED      = 3'd5;
    localparam logic [2:0] ST_SUSPENDED    = 3'd6;
    localparam logic [2:0] ST_RESUMING     = 3'd7;

    // The phase counter is shared by every timed state, so it is sized for
    // the largest of the timing parameters.
    localparam int unsigned MAX_1   = (DEBOUNCE_CYCLES > BUS_RESET_CYCLES) ? DEBOUNCE_CYCLES : BUS_RESET_CYCLES;
    localparam int unsigned MAX_2   = (MAX_1 > RECOVERY_CYCLES) ? MAX_1 : RECOVERY_CYCLES;
    localparam int unsigned MAX_3   = (MAX_2 > DISCONNECT_CYCLES) ? MAX_2 : DISCONNECT_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_3 > RESUME_CYCLES) ? MAX_3 : RESUME_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned SE0_W   = $clog2(DISCONNECT_CYCLES + 1);

    // A timed state exits on the edge that ends its last cycle, i.e. when the
    // counter already shows N-1 elapsed cycles.
    localparam logic [CNT_W-1:0] DEBOUNCE_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BUS_RESET_LAST = CNT_W'(BUS_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVERY_LAST  = CNT_W'(RECOVERY_CYCLES - 1);
    localparam logic [SE0_W-1:0] SE0_SAT        = SE0_W'(DISCONNECT_CYCLES);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SE0_W-1:0] se0_cnt_q, se0_cnt_d;
    logic [1:0]       cand_q, cand_d;
    logic             low_speed_q, low_speed_d;
    logic             drive_en_q, drive_en_d;
    logic             drive_se0_q, drive_se0_d;
    logic             drive_k_q, drive_k_d;
    logic             connected_q, connected_d;
    logic             port_enabled_q, port_enabled_d;
    logic             connect_q, connect_d;
    logic             disconnect_q, disconnect_d;
    logic             reset_done_q, reset_done_d;
    logic             port_error_q, port_error_d;
    logic             line_is_j;
    logic             se0_sat;

`ifdef USB_PORT_SUSPEND_EN
    localparam logic [CNT_W-1:0] RESUME_LAST = CNT_W'(RESUME_CYCLES - 1);
    logic [1:0] k_line;

    // K is the inverse of the J polarity latched at attach/recovery.
    assign k_line = low_speed_q ? 2'b10 : 2'b01;
`else
    logic unused_reqs;

    assign unused_reqs = suspend_req | resume_req;
`endif

    assign line_is_j = (usb_line == 2'b10) || (usb_line == 2'b01);

    // Undriven-SE0 run length. While we drive the bus the line reflects our
    // own drive, so the count is held at zero.
    always_comb begin
        if ((usb_line != 2'b00) || drive_en_q) begin
            se0_cnt_d = '0;
        end else if (se0_cnt_q == SE0_SAT) begin
            se0_cnt_d = se0_cnt_q;
        end else begin
            se0_cnt_d = se0_cnt_q + SE0_W'(1);
        end
    end

    // Saturation is judged on the count including this cycle's sample, so
    // DISCONNECT_CYCLES SE0 samples are exactly enough.
    assign se0_sat = (se0_cnt_d == SE0_SAT);

    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;   // counter clears unless a state extends its run
        cand_d       = cand_q;
        low_speed_d  = low_speed_q;
        connect_d    = 1'b0;
        disconnect_d = 1'b0;
        reset_done_d = 1'b0;
        port_error_d = 1'b0;

        case (state_q)
            ST_DISCONNECTED: begin
                if (line_is_j) begin
                    cand_d  = usb_line;
                    state_d = ST_DEBOUNCE;
                end
            end

            ST_DEBOUNCE: begin
                if (usb_line != cand_q) begin
                    state_d = ST_DISCONNECTED;
                end else if (cnt_q == DEBOUNCE_LAST) begin
                    state_d     = ST_ATTACHED;
                    low_speed_d = (cand_q == 2'b01);
                    connect_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_ATTACHED: begin
                if (se0_sat) begin
                    state_d      = ST_DISCONNECTED;
                    disconnect_d = 1'b1;
                end else if (port_reset_req) begin
                    state_d = ST_BUS_RESET;
                end
            end

            ST_BUS_RESET: begin
                if (cnt_q == BUS_RESET_LAST) begin
                    state_d = ST_RECOVERY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RECOVERY: begin
                if (cnt_q == RECOVERY_LAST) begin
                    case (usb_line)
                        2'b10, 2'b01: begin
                            state_d      = ST_ENABLED;
                            low_speed_d  = (usb_line == 2'b01);
                            reset_done_d = 1'b1;
                        end
                        2'b00: begin
                            state_d      = ST_DISCONNECTED;
                            disconnect_d = 1'b1;
                        end
                        default: begin
                            state_d      = ST_ATTACHED;
                            port_error_d = 1'b1;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_ENABLED: begin
                if (se0_sat) begin
                    state_d      = ST_DISCONNECTED;
                    disconnect_d = 1'b1;
                end else if (port_reset_req) begin
                    state_d = ST_BUS_RESET;
                end else if (port_disable_req) begin
                    state_d = ST_ATTACHED;
`ifdef USB_PORT_SUSPEND_EN
                end else if (suspend_req) begin
                    state_d = ST_SUSPENDED;
`endif
                end
            end

`ifdef USB_PORT_SUSPEND_EN
            ST_SUSPENDED: begin
                if (se0_sat) begin
                    state_d      = ST_DISCONNECTED;
                    disconnect_d = 1'b1;
                end else if (resume_req) begin
                    state_d = ST_RESUMING;
                end else if (usb_line == k_line) begin
                    // Remote wakeup: K must be held for a full debounce run.
                    if (cnt_q == DEBOUNCE_LAST) begin
                        state_d = ST_RESUMING;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_RESUMING: begin
                if (cnt_q == RESUME_LAST) begin
                    state_d = ST_ENABLED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            default: begin
                state_d = ST_DISCONNECTED;
            end
        endcase
    end

    // Status outputs are registered from the next state so they change on the
    // same edge as port_state.
    always_comb begin
        drive_en_d     = (state_d == ST_BUS_RESET) || (state_d == ST_RESUMING);
        drive_se0_d    = (state_d == ST_BUS_RESET);
`ifdef USB_PORT_SUSPEND_EN
        drive_k_d      = (state_d == ST_RESUMING);
`else
        drive_k_d      = 1'b0;
`endif
        connected_d    = (state_d >= ST_ATTACHED);
        port_enabled_d = (state_d == ST_ENABLED);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_DISCONNECTED;
            cnt_q          <= '0;
            se0_cnt_q      <= '0;
            cand_q         <= 2'b00;
            low_speed_q    <= 1'b0;
            drive_en_q     <= 1'b0;
            drive_se0_q    <= 1'b0;
            drive_k_q      <= 1'b0;
            connected_q    <= 1'b0;
            port_enabled_q <= 1'b0;
            connect_q      <= 1'b0;
            disconnect_q   <= 1'b0;
            reset_done_q   <= 1'b0;
            port_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            se0_cnt_q      <= se0_cnt_d;
            cand_q         <= cand_d;
            low_speed_q    <= low_speed_d;
            drive_en_q     <= drive_en_d;
            drive_se0_q    <= drive_se0_d;
            drive_k_q      <= drive_k_d;
            connected_q    <= connected_d;
            port_enabled_q <= port_enabled_d;
            connect_q      <= connect_d;
            disconnect_q   <= disconnect_d;
            reset_done_q   <= reset_done_d;
            port_error_q   <= port_error_d;
        end
    end

    assign port_state       = state_q;
    assign drive_en         = drive_en_q;
    assign drive_se0        = drive_se0_q;
    assign drive_k          = drive_k_q;
    assign connected        = connected_q;
    assign port_enabled     = port_enabled_q;
    assign low_speed        = low_speed_q;
    assign connect_pulse    = connect_q;
    assign disconnect_pulse = disconnect_q;
    assign reset_done_pulse = reset_done_q;
    assign port_error_pulse = port_error_q;

endmodule

// File: tb/tb_usb_host_port_controller.sv
// -----------------------------------------------------------------------------
// tb_usb_host_port_controller
//
// Self-checking bench for usb_host_port_controller with short timing
// parameters. A behavioural port model (dwell times and run lengths kept as
// plain integers) is stepped every clock and compared against the DUT; a
// vector table and hand-written sequences add explicit expectations for the
// attach, reset, disconnect, priority, recovery-fault, async-reset and
// suspend/resume (USB_PORT_SUSPEND_EN) scenarios, followed by random traffic.
// -----------------------------------------------------------------------------
module tb_usb_host_port_controller;

    localparam int unsigned DEB_N  = 8;
    localparam int unsigned BR_N   = 16;
    localparam int unsigned REC_N  = 4;
    localparam int unsigned DISC_N = 6;
    localparam int unsigned RES_N  = 10;
`ifdef USB_PORT_SUSPEND_EN
    localparam bit SUSPEND_FEATURE = 1'b1;
`else
    localparam bit SUSPEND_FEATURE = 1'b0;
`endif

    typedef enum int {
        P_DISCONNECTED = 0, P_DEBOUNCE = 1, P_ATTACHED = 2, P_BUS_RESET = 3,
        P_RECOVERY = 4, P_ENABLED = 5, P_SUSPENDED = 6, P_RESUMING = 7
    } pstate_e;

    typedef struct {
        logic [1:0] line;
        logic       rr;
        logic       dr;
        int         n;
        logic [2:0] st;
        logic       den;
        logic       ls;
        int         conn;
        int         disc;
        int         rdone;
        int         err;
    } vec_t;

    logic       clock;
    logic       reset;
    logic [1:0] usb_line;
    logic       port_reset_req;
    logic       port_disable_req;
    logic       suspend_req;
    logic       resume_req;
    logic       drive_en;
    logic       drive_se0;
    logic       drive_k;
    logic [2:0] port_state;
    logic       connected;
    logic       port_enabled;
    logic       low_speed;
    logic       connect_pulse;
    logic       disconnect_pulse;
    logic       reset_done_pulse;
    logic       port_error_pulse;

    int n_checks;
    int n_fail;

    // Reference model state
    pstate_e    m_state;
    int         m_age;   // edges spent in current state
    int         m_run;   // consecutive K samples while suspended
    int         m_se0;   // consecutive undriven SE0 samples
    logic [1:0] m_cand;
    logic       m_ls;
    logic       m_conn, m_disc, m_rd, m_err;

    // Pulse tallies over one apply() window
    int c_conn, c_disc, c_rd, c_err;

    vec_t tbl[$];

    usb_host_port_controller #(
        .DEBOUNCE_CYCLES  (DEB_N),
        .BUS_RESET_CYCLES (BR_N),
        .RECOVERY_CYCLES  (REC_N),
        .DISCONNECT_CYCLES(DISC_N),
        .RESUME_CYCLES    (RES_N)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .usb_line        (usb_line),
        .port_reset_req  (port_reset_req),
        .port_disable_req(port_disable_req),
        .suspend_req     (suspend_req),
        .resume_req      (resume_req),
        .drive_en        (drive_en),
        .drive_se0       (drive_se0),
        .drive_k         (drive_k),
        .port_state      (port_state),
        .connected       (connected),
        .port_enabled    (port_enabled),
        .low_speed       (low_speed),
        .connect_pulse   (connect_pulse),
        .disconnect_pulse(disconnect_pulse),
        .reset_done_pulse(reset_done_pulse),
        .port_error_pulse(port_error_pulse)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = P_DISCONNECTED;
        m_age   = 0;
        m_run   = 0;
        m_se0   = 0;
        m_cand  = 2'b00;
        m_ls    = 1'b0;
        m_conn  = 1'b0;
        m_disc  = 1'b0;
        m_rd    = 1'b0;
        m_err   = 1'b0;
    endtask

    // One clock of port behaviour from the sampled inputs.
    task automatic model_step(input logic [1:0] line, input logic rr, input logic dr,
                              input logic sr, input logic qr);
        pstate_e    nxt;
        logic [1:0] k_line;
        bit         driving;
        bit         gone;
        driving = (m_state == P_BUS_RESET) || (m_state == P_RESUMING);
        if (line != 2'b00 || driving) m_se0 = 0;
        else m_se0++;
        gone   = (m_se0 >= DISC_N);
        k_line = m_ls ? 2'b10 : 2'b01;
        nxt    = m_state;
        m_conn = 1'b0;
        m_disc = 1'b0;
        m_rd   = 1'b0;
        m_err  = 1'b0;
        case (m_state)
            P_DISCONNECTED: begin
                if (line == 2'b10 || line == 2'b01) begin
                    m_cand = line;
                    nxt    = P_DEBOUNCE;
                end
            end
            P_DEBOUNCE: begin
                if (line != m_cand) nxt = P_DISCONNECTED;
                else if (m_age + 1 >= DEB_N) begin
                    nxt    = P_ATTACHED;
                    m_ls   = (m_cand == 2'b01);
                    m_conn = 1'b1;
                end
            end
            P_ATTACHED: begin
                if (gone) begin
                    nxt    = P_DISCONNECTED;
                    m_disc = 1'b1;
                end else if (rr) nxt = P_BUS_RESET;
            end
            P_BUS_RESET: begin
                if (m_age + 1 >= BR_N) nxt = P_RECOVERY;
            end
            P_RECOVERY: begin
                if (m_age + 1 >= REC_N) begin
                    if (line == 2'b10 || line == 2'b01) begin
                        nxt  = P_ENABLED;
                        m_ls = (line == 2'b01);
                        m_rd = 1'b1;
                    end else if (line == 2'b00) begin
                        nxt    = P_DISCONNECTED;
                        m_disc = 1'b1;
                    end else begin
                        nxt   = P_ATTACHED;
                        m_err = 1'b1;
                    end
                end
            end
            P_ENABLED: begin
                if (gone) begin
                    nxt    = P_DISCONNECTED;
                    m_disc = 1'b1;
                end else if (rr) nxt = P_BUS_RESET;
                else if (dr) nxt = P_ATTACHED;
                else if (sr && SUSPEND_FEATURE) nxt = P_SUSPENDED;
            end
            P_SUSPENDED: begin
                if (gone) begin
                    nxt    = P_DISCONNECTED;
                    m_disc = 1'b1;
                end else if (qr) nxt = P_RESUMING;
                else if (line == k_line) begin
                    m_run++;
                    if (m_run >= DEB_N) nxt = P_RESUMING;
                end else m_run = 0;
            end
            default: begin
                if (m_age + 1 >= RES_N) nxt = P_ENABLED;
            end
        endcase
        if (nxt != m_state) begin
            m_age = 0;
            m_run = 0;
        end else begin
            m_age++;
        end
        m_state = nxt;
    endtask

    function automatic logic [12:0] model_vec();
        logic [2:0] s;
        s = 3'(int'(m_state));
        return {s, (s == 3'd3) || (s == 3'd7), s == 3'd3, s == 3'd7, s >= 3'd2,
                s == 3'd5, m_ls, m_conn, m_disc, m_rd, m_err};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {port_state, drive_en, drive_se0, drive_k, connected, port_enabled,
                low_speed, connect_pulse, disconnect_pulse, reset_done_pulse, port_error_pulse};
    endfunction

    task automatic tick();
        model_step(usb_line, port_reset_req, port_disable_req, suspend_req, resume_req);
        @(posedge clock);
        #1;
        check("model", 32'(dut_vec()), 32'(model_vec()));
        c_conn += int'(connect_pulse);
        c_disc += int'(disconnect_pulse);
        c_rd   += int'(reset_done_pulse);
        c_err  += int'(port_error_pulse);
    endtask

    task automatic apply(input logic [1:0] line, input logic rr, input logic dr,
                         input logic sr, input logic qr, input int n);
        usb_line         = line;
        port_reset_req   = rr;
        port_disable_req = dr;
        suspend_req      = sr;
        resume_req       = qr;
        c_conn = 0;
        c_disc = 0;
        c_rd   = 0;
        c_err  = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic add_vec(input logic [1:0] line, input logic rr, input logic dr, input int n,
                           input logic [2:0] st, input logic den, input logic ls,
                           input int c, input int d, input int r, input int e);
        vec_t v;
        v.line = line; v.rr = rr; v.dr = dr; v.n = n;
        v.st = st; v.den = den; v.ls = ls;
        v.conn = c; v.disc = d; v.rdone = r; v.err = e;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // Attach at full speed, reset and recover into ENABLED.
    task automatic bring_up_fs();
        apply(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, DEB_N + 1);
        apply(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        apply(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, BR_N + REC_N);
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        reset            = 1'b1;
        usb_line         = 2'b00;
        port_reset_req   = 1'b0;
        port_disable_req = 1'b0;
        suspend_req      = 1'b0;
        resume_req       = 1'b0;
        model_reset();

        //       line   rr    dr    n   st  den  ls  c  d  r  e
        add_vec(2'b00, 1'b0, 1'b0, 3,  0, 0, 0, 0, 0, 0, 0); // idle
        add_vec(2'b10, 1'b0, 1'b0, 5,  1, 0, 0, 0, 0, 0, 0); // short J
        add_vec(2'b00, 1'b0, 1'b0, 1,  0, 0, 0, 0, 0, 0, 0); // glitch aborts
        add_vec(2'b10, 1'b0, 1'b0, 9,  2, 0, 0, 1, 0, 0, 0); // FS attach
        add_vec(2'b10, 1'b0, 1'b0, 3,  2, 0, 0, 0, 0, 0, 0);
        add_vec(2'b00, 1'b0, 1'b0, 5,  2, 0, 0, 0, 0, 0, 0); // SE0 below limit
        add_vec(2'b00, 1'b0, 1'b0, 1,  0, 0, 0, 0, 1, 0, 0); // disconnect
        add_vec(2'b01, 1'b0, 1'b0, 9,  2, 0, 1, 1, 0, 0, 0); // LS attach
        add_vec(2'b01, 1'b1, 1'b0, 1,  3, 1, 1, 0, 0, 0, 0); // bus reset
        add_vec(2'b01, 1'b0, 1'b0, 15, 3, 1, 1, 0, 0, 0, 0); // 16th reset cycle
        add_vec(2'b01, 1'b0, 1'b0, 1,  4, 0, 1, 0, 0, 0, 0); // recovery
        add_vec(2'b01, 1'b0, 1'b0, 3,  4, 0, 1, 0, 0, 0, 0);
        add_vec(2'b01, 1'b0, 1'b0, 1,  5, 0, 1, 0, 0, 1, 0); // enabled LS
        add_vec(2'b00, 1'b0, 1'b0, 5,  5, 0, 1, 0, 0, 0, 0); // 5 SE0 tolerated
        add_vec(2'b01, 1'b0, 1'b0, 2,  5, 0, 1, 0, 0, 0, 0);
        add_vec(2'b00, 1'b0, 1'b0, 6,  0, 0, 1, 0, 1, 0, 0); // 6 SE0 -> gone
        add_vec(2'b10, 1'b0, 1'b0, 9,  2, 0, 0, 1, 0, 0, 0);
        add_vec(2'b10, 1'b1, 1'b0, 1,  3, 1, 0, 0, 0, 0, 0);
        add_vec(2'b10, 1'b0, 1'b0, 16, 4, 0, 0, 0, 0, 0, 0);
        add_vec(2'b10, 1'b0, 1'b0, 4,  5, 0, 0, 0, 0, 1, 0);
        add_vec(2'b00, 1'b0, 1'b0, 5,  5, 0, 0, 0, 0, 0, 0);
        add_vec(2'b00, 1'b1, 1'b0, 1,  0, 0, 0, 0, 1, 0, 0); // disconnect beats reset
        add_vec(2'b10, 1'b0, 1'b0, 9,  2, 0, 0, 1, 0, 0, 0);
        add_vec(2'b10, 1'b1, 1'b0, 1,  3, 1, 0, 0, 0, 0, 0);
        add_vec(2'b10, 1'b0, 1'b0, 20, 5, 0, 0, 0, 0, 1, 0);
        add_vec(2'b10, 1'b1, 1'b1, 1,  3, 1, 0, 0, 0, 0, 0); // reset beats disable
        add_vec(2'b00, 1'b0, 1'b0, 20, 0, 0, 0, 0, 1, 0, 0); // SE0 at recovery end
        add_vec(2'b01, 1'b0, 1'b0, 9,  2, 0, 1, 1, 0, 0, 0);
        add_vec(2'b01, 1'b1, 1'b0, 1,  3, 1, 1, 0, 0, 0, 0);
        add_vec(2'b11, 1'b0, 1'b0, 20, 2, 0, 1, 0, 0, 0, 1); // SE1 at recovery end
        add_vec(2'b01, 1'b1, 1'b0, 1,  3, 1, 1, 0, 0, 0, 0);
        add_vec(2'b01, 1'b1, 1'b0, 20, 5, 0, 1, 0, 0, 1, 0); // held request
        add_vec(2'b01, 1'b1, 1'b0, 1,  3, 1, 1, 0, 0, 0, 0); // re-evaluated

        repeat (3) @(posedge clock);
        #1;
        check("reset outputs", 32'(dut_vec()), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].line, tbl[i].rr, tbl[i].dr, 1'b0, 1'b0, tbl[i].n);
            check($sformatf("row%0d port_state", i), 32'(port_state), 32'(tbl[i].st));
            check($sformatf("row%0d drive_en", i), 32'(drive_en), 32'(tbl[i].den));
            check($sformatf("row%0d low_speed", i), 32'(low_speed), 32'(tbl[i].ls));
            check($sformatf("row%0d connect count", i), 32'(c_conn), 32'(tbl[i].conn));
            check($sformatf("row%0d disconnect count", i), 32'(c_disc), 32'(tbl[i].disc));
            check($sformatf("row%0d reset_done count", i), 32'(c_rd), 32'(tbl[i].rdone));
            check($sformatf("row%0d error count", i), 32'(c_err), 32'(tbl[i].err));
        end

        // Asynchronous reset in the middle of bus reset.
        apply(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        check("mid bus reset state", 32'(port_state), 32'd3);
        check("mid bus reset drive_se0", 32'(drive_se0), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async reset drive_en", 32'(drive_en), 32'd0);
        check("async reset drive_se0", 32'(drive_se0), 32'd0);
        check("async reset state", 32'(port_state), 32'd0);
        check("async reset connected", 32'(connected), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;

`ifdef USB_PORT_SUSPEND_EN
        bring_up_fs();
        check("pre-suspend state", 32'(port_state), 32'd5);
        apply(2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        check("suspend state", 32'(port_state), 32'd6);
        check("suspend connected", 32'(connected), 32'd1);
        check("suspend port_enabled", 32'(port_enabled), 32'd0);
        check("suspend drive_en", 32'(drive_en), 32'd0);
        apply(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        apply(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, DEB_N - 1);
        check("K short of wakeup", 32'(port_state), 32'd6);
        apply(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        check("remote wakeup state", 32'(port_state), 32'd7);
        check("resume drive_k", 32'(drive_k), 32'd1);
        check("resume drive_en", 32'(drive_en), 32'd1);
        apply(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, RES_N - 1);
        check("resume last cycle", {29'd0, port_state}, 32'd7);
        apply(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        check("resume done state", 32'(port_state), 32'd5);
        check("resume no reset_done", 32'(c_rd), 32'd0);
        check("resume drive_k off", 32'(drive_k), 32'd0);
        apply(2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        apply(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        check("host resume state", 32'(port_state), 32'd7);
        apply(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, RES_N);
        check("host resume done", 32'(port_state), 32'd5);
`else
        bring_up_fs();
        check("pre-suspend state", 32'(port_state), 32'd5);
        apply(2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 3);
        check("suspend ignored state", 32'(port_state), 32'd5);
        check("suspend ignored drive_k", 32'(drive_k), 32'd0);
        check("suspend ignored drive_en", 32'(drive_en), 32'd0);
`endif

        // Random traffic against the model.
        do_reset();
        for (int seg = 0; seg < 400; seg++) begin
            int         r;
            int         len;
            logic [1:0] line;
            r = int'($urandom_range(0, 9));
            if (r < 4)      line = 2'b10;
            else if (r < 6) line = 2'b01;
            else if (r < 9) line = 2'b00;
            else            line = 2'b11;
            len = (line == 2'b00) ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 24));
            for (int i = 0; i < len; i++) begin
                usb_line         = line;
                port_reset_req   = ($urandom_range(0, 24) == 0);
                port_disable_req = ($urandom_range(0, 29) == 0);
                suspend_req      = ($urandom_range(0, 24) == 0);
                resume_req       = ($urandom_range(0, 39) == 0);
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_host_port_controller.md
Name: usb_host_port_controller

Overview:
- Per-port host-side sequencer for a downstream USB port. It watches the sampled D+/D- line state, debounces device attach, and latches full/low speed from J-state polarity.
- On request it drives bus reset (SE0), runs reset recovery, enables the port and detects disconnect.
- Sits between the raw line sampler and the hub/host port-status logic. It owns the SE0/K drive enables for the transceiver.

Parameters:
- DEBOUNCE_CYCLES, 100: consecutive stable-J cycles required to accept attach; also the K-hold time for remote wakeup.
- BUS_RESET_CYCLES, 1000: cycles SE0 is driven during bus reset.
- RECOVERY_CYCLES, 10: idle cycles after bus reset before line is checked.
- DISCONNECT_CYCLES, 20: consecutive undriven SE0 cycles that signal disconnect. Must exceed EOP length.
- RESUME_CYCLES, 200: cycles K is driven for resume. Used only with USB_PORT_SUSPEND_EN.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- usb_line  in  2  sampled line, [1]=D+, [0]=D-. 10=FS J, 01=LS J, 00=SE0, 11=SE1
- port_reset_req  in  1  level; request bus reset
- port_disable_req  in  1  level; request port disable
- suspend_req  in  1  level; request suspend. Ignored without USB_PORT_SUSPEND_EN
- resume_req  in  1  level; request host resume. Ignored without USB_PORT_SUSPEND_EN
- drive_en  out  1  transceiver output enable
- drive_se0  out  1  drive SE0 (valid when drive_en)
- drive_k  out  1  drive K state (valid when drive_en)
- port_state  out  3  current FSM state encoding
- connected  out  1  device present (ATTACHED or later)
- port_enabled  out  1  state is ENABLED
- low_speed  out  1  latched speed, 1 = low speed
- connect_pulse  out  1  one-cycle pulse on attach accepted
- disconnect_pulse  out  1  one-cycle pulse on disconnect
- reset_done_pulse  out  1  one-cycle pulse on entry to ENABLED from RECOVERY
- port_error_pulse  out  1  one-cycle pulse on SE1 at recovery end

Behaviour:
- Reset values: state DISCONNECTED; all outputs 0; counters 0; low_speed 0.
- Reset is asynchronous. Asserting it mid-operation aborts immediately and releases drive_en on the same edge.
- States (port_state): 0 DISCONNECTED, 1 DEBOUNCE, 2 ATTACHED, 3 BUS_RESET, 4 RECOVERY, 5 ENABLED, 6 SUSPENDED, 7 RESUMING.
- Counters: one shared phase counter, width clog2(max parameter + 1), cleared on every state change. One separate SE0 counter, saturating at DISCONNECT_CYCLES, cleared whenever usb_line != 00 or drive_en = 1.
- DISCONNECTED:
  - usb_line of 10 or 01: capture it as cand, go to DEBOUNCE.
  - 00/11: stay.
- DEBOUNCE:
  - usb_line == cand: count.
  - When the count reaches DEBOUNCE_CYCLES: go to ATTACHED, low_speed <= (cand==01), pulse connect_pulse.
  - Any mismatch: back to DISCONNECTED, no pulse.
- ATTACHED:
  - SE0 counter saturates: go to DISCONNECTED, pulse disconnect_pulse.
  - Else port_reset_req: go to BUS_RESET.
- BUS_RESET:
  - drive_en=1, drive_se0=1 for exactly BUS_RESET_CYCLES cycles, then RECOVERY.
  - Requests are ignored. Disconnect is not evaluated (line is driven).
- RECOVERY:
  - drive_en=0 for RECOVERY_CYCLES cycles, then sample usb_line.
  - J (10/01): relatch low_speed, go to ENABLED, pulse reset_done_pulse.
  - 00: go to DISCONNECTED, pulse disconnect_pulse.
  - 11: go to ATTACHED, pulse port_error_pulse.
- ENABLED:
  - Priority, highest first: disconnect (SE0 counter saturated) > port_reset_req (to BUS_RESET) > port_disable_req (to ATTACHED) > suspend_req (to SUSPENDED, feature only).
  - Only one transition per cycle.
- All outputs are registered. Pulses assert on the cycle the new state is first visible on port_state.
- connected = 1 in states 2..7. port_enabled = 1 only in state 5.
- Requests are level-sampled. A request held across a transition is re-evaluated in the new state. Example: port_reset_req still high on entering ENABLED triggers another bus reset.

Optional Feature:
- Macro: USB_PORT_SUSPEND_EN.
- Defined, SUSPENDED:
  - Outputs undriven. port_enabled=0, connected=1.
  - resume_req: go to RESUMING.
  - Line == K (inverse of latched J) for DEBOUNCE_CYCLES consecutive cycles: go to RESUMING (remote wakeup).
  - SE0 counter saturates: go to DISCONNECTED, pulse disconnect_pulse.
- Defined, RESUMING: drive_en=1, drive_k=1 for RESUME_CYCLES cycles, then ENABLED. No reset_done_pulse.
- Not defined: suspend_req/resume_req are ignored, drive_k is constant 0, and states 6/7 are unreachable. Any illegal state recovers to DISCONNECTED next cycle.

Test Plan (DEBOUNCE=8, BUS_RESET=16, RECOVERY=4, DISCONNECT=6, RESUME=10):
- FS attach:
  - Stimulus: usb_line 00 -> 10, held 8 cycles.
  - Response: connect_pulse once, port_state=2, low_speed=0.
  - Glitch case: line 10 for 5 cycles, then 00. Response: back to state 0, no pulse.
- LS attach then reset:
  - Stimulus: line 01 stable, then port_reset_req=1.
  - Response: drive_en=drive_se0=1 for exactly 16 cycles, 4 idle cycles, then line 01 gives reset_done_pulse, port_enabled=1, low_speed=1.
- Disconnect:
  - In ENABLED, SE0 for 5 cycles then J: stays enabled.
  - SE0 for 6 cycles: disconnect_pulse, port_state=0, port_enabled=0.
- Simultaneous events:
  - In ENABLED, SE0 counter saturates on the same cycle as port_reset_req=1: DISCONNECTED wins.
  - port_reset_req=1 together with port_disable_req=1: goes to BUS_RESET.
- Recovery faults:
  - Line 00 at recovery end: disconnect_pulse.
  - Line 11 at recovery end: port_error_pulse, state 2.
  - reset asserted mid BUS_RESET: drive_en drops immediately, state 0.
- Suspend/resume (USB_PORT_SUSPEND_EN):
  - suspend_req gives state 6.
  - Line K (01 for FS) for 8 cycles gives state 7, drive_k=1 for 10 cycles, then ENABLED.
  - Macro undefined: suspend_req has no effect.
